bus_arbiter_2: RTL
==================

// Module: bus_arbiter_2
// PURPOSE
//  Two-host to one-target bus arbiter. Lets the CPU core and a second master (DMA / debug) share
//  the host port of the address-decoding hub (memory + SPRAM). Uses the same bus protocol on all
//  sides: addr/wdata/wmask/wen/ren/rdata/done. Grant is locked per transaction; optional watchdog
//  completes hung transactions.
// PARAMETERS
//  FIXED_PRIORITY  0       0 = round-robin; 1 = host 0 always wins simultaneous requests
//  TIMEOUT_CYCLES  0       cycles a granted transaction may wait for dev_done; 0 = watchdog off
//  TIMEOUT_RDATA   32'hDEADBEEF  rdata returned to host on watchdog completion
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, asynchronous, active-high
//  h0_addr        in   32  host 0 byte address
//  h0_wdata       in   32  host 0 write data
//  h0_wmask       in   4   host 0 byte write mask
//  h0_wen         in   1   host 0 write request, held until h0_done
//  h0_ren         in   1   host 0 read request, held until h0_done
//  h0_rdata       out  32  host 0 read data, valid when h0_done
//  h0_done        out  1   host 0 completion pulse
//  h1_*           -    -   identical set for host 1
//  dev_addr       out  32  to hub host_address
//  dev_wdata      out  32  to hub host_data_write
//  dev_wmask      out  4   to hub host_write_mask
//  dev_wen        out  1   to hub host_wen
//  dev_ren        out  1   to hub host_ren
//  dev_rdata      in   32  from hub host_data_read
//  dev_done       in   1   from hub host_ready
//  grant          out  2   one-hot current owner, 2'b00 = idle
//  timeout        out  1   one-cycle pulse when watchdog completes a transaction
// BEHAVIOUR
//  - Reset (async): state IDLE, grant=00, last=1 (host 0 wins first), watchdog=0,
//    timeout=0; all dev_* strobes and h*_done read 0.
//  - Request: hN_req = hN_wen | hN_ren. Host contract: deassert the request in the cycle after done.
//  - FSM IDLE -> OWN0/OWN1 -> IDLE; state and grant registered.
//    IDLE: sample requests; single requester wins. Both requesting: FIXED_PRIORITY=1 -> host 0;
//    else host != last. Cycle N request -> dev_wen/dev_ren high in cycle N+1
//    (1-cycle arbitration latency).
//    OWNk: dev_* = hk_* combinationally (mux on grant); non-owner sees done=0, rdata=0.
//    dev_done in OWNk -> hk_done=1 and hk_rdata=dev_rdata same cycle; next state IDLE; last=k.
//  - Minimum spacing: one IDLE cycle between transactions; back-to-back peak = 1 txn / (dev latency + 1).
//  - Owner withdrawing request before done: protocol violation. Grant is held; dev strobes follow
//    the owner's (now low) inputs; completion still requires dev_done or timeout.
//  - Watchdog (TIMEOUT_CYCLES>0): counter clears on entering OWNk, increments each OWNk cycle
//    without dev_done. Reaching TIMEOUT_CYCLES -> hk_done=1, hk_rdata=TIMEOUT_RDATA,
//    timeout=1 for one cycle. Next state IDLE; last=k.
//    dev_done in the same cycle as expiry wins: normal completion, no timeout pulse.
//    Counter width $clog2(TIMEOUT_CYCLES+1); counter saturates and never wraps.
//  - Late dev_done arriving in IDLE after a timeout: ignored, no host done.
//  - Reset mid-transaction: dev strobes drop immediately (async); no done is issued.
// STRUCTURE
//  - bus_pkg: state enum (ARB_IDLE, ARB_OWN0, ARB_OWN1) and default TIMEOUT_RDATA constant.
//  - Sub-module bus_watchdog (counter + expiry compare, clear/enable inputs). Mux and FSM inline.
// TESTING
//  - Single host 0 read of 0x100 (mem done at +1): dev_ren high cycle N+1; h0_done one cycle
//    with mem data; grant 01 -> 00.
//  - Both request at cycle N after reset, round-robin: host 0 served first, then host 1 after one
//    IDLE cycle; h1 never sees a done during host 0's transaction.
//  - Host 0 requests continuously, host 1 requests once: grants alternate 0,1,0. With
//    FIXED_PRIORITY=1, host 1 waits until host 0 idles.
//  - Write from host 1, wmask=4'b0011, data 0xAABBCCDD to SPRAM: dev_wmask/wdata pass through;
//    readback by host 0 returns 0x....CCDD.
//  - TIMEOUT_CYCLES=8 with dev_done tied 0: h0_done plus timeout exactly 8 cycles after grant,
//    rdata 0xDEADBEEF. Same test with dev_done on cycle 8: normal done, timeout stays 0.
//  - Assert rst during an OWN1 transaction: grant=00 and dev_ren=0 in the same cycle;
//    after release, host 0 wins first.

Source files
------------

// File: rtl/bus_arbiter_2_pkg.sv
// Shared types and constants for the two-host bus arbiter.
// Contents: bus widths, arbiter state enum, request payload struct,
// default watchdog read data, and a state-to-grant helper.
package bus_arbiter_2_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = DATA_W / 8;

   localparam logic [DATA_W-1:0] TIMEOUT_RDATA_DEFAULT = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_e;

   // Host-to-target request payload, muxed as one unit onto the device port
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [MASK_W-1:0] wmask;
      logic              wen;
      logic              ren;
   } bus_req_t;

   // One-hot owner encoding for a given state; idle is 2'b00
   function automatic logic [1:0] grant_of(input arb_state_e s);
      logic [1:0] g;
      g = 2'b00;
      case (s)
         ARB_OWN0: g = 2'b01;
         ARB_OWN1: g = 2'b10;
         default:  g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/bus_arbiter_2_if.sv
// Simple bus link: addr/wdata/wmask/wen/ren from the requester,
// rdata/done back from the responder.
// Modports:
//   master - drives the request (addr, wdata, wmask, wen, ren), sees rdata/done
//   slave  - receives the request, drives rdata/done
interface bus_arbiter_2_if;
   import bus_arbiter_2_pkg::*;

   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [MASK_W-1:0] wmask;
   logic              wen;
   logic              ren;
   logic [DATA_W-1:0] rdata;
   logic              done;

   modport master (
      output addr, wdata, wmask, wen, ren,
      input  rdata, done
   );

   modport slave (
      input  addr, wdata, wmask, wen, ren,
      output rdata, done
   );

endinterface

// File: rtl/bus_arbiter_2_watchdog.sv
// Transaction watchdog: saturating cycle counter with expiry compare.
// Ports:
//   clk, rst  - clock, async active-high reset
//   clr       - hold counter at zero (arbiter idle)
//   en        - count this cycle (owned, no completion yet)
//   expired   - counter has reached TIMEOUT_CYCLES; always 0 when TIMEOUT_CYCLES == 0
module bus_arbiter_2_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   // Keep at least one bit so a disabled watchdog still elaborates
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] count_q;

   // Saturates at LIMIT so a stuck owner can never wrap back below expiry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en && (count_q != LIMIT)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign expired = (TIMEOUT_CYCLES != 0) && (count_q == LIMIT);

endmodule

// File: rtl/bus_arbiter_2.sv
// Two-host to one-target bus arbiter with per-transaction grant lock and
// optional watchdog completion of hung transactions.
// Ports:
//   clk, rst  - clock, async active-high reset
//   h0, h1    - host links (slave side): request in, rdata/done out
//   dev       - target link (master side): muxed request out, rdata/done in
//   grant     - registered one-hot owner, 2'b00 when idle
//   timeout   - one-cycle pulse when the watchdog completes a transaction
module bus_arbiter_2
   import bus_arbiter_2_pkg::*;
#(
   parameter bit                FIXED_PRIORITY = 1'b0,
   parameter int unsigned       TIMEOUT_CYCLES = 0,
   parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = TIMEOUT_RDATA_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   bus_arbiter_2_if.slave  h0,
   bus_arbiter_2_if.slave  h1,
   bus_arbiter_2_if.master dev,
   output logic [1:0]      grant,
   output logic            timeout
);

   arb_state_e        state_q, state_d;
   logic              last_q, last_d;     // 1: host 1 served most recently
   logic [1:0]        grant_q;
   logic              req0, req1;
   logic              wd_expired;
   logic              owning;
   logic              h0_done_c, h1_done_c, timeout_c;
   logic [DATA_W-1:0] owner_rdata;
   bus_req_t          h0_bus, h1_bus, dev_bus;

   assign req0   = h0.wen | h0.ren;
   assign req1   = h1.wen | h1.ren;
   assign owning = (state_q != ARB_IDLE);

   bus_arbiter_2_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (!owning),
      .en      (owning && !dev.done),
      .expired (wd_expired)
   );

   // State, last-served and grant registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         last_q  <= 1'b1;
         grant_q <= 2'b00;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_of(state_d);
      end
   end

   // Next-state and completion decode; dev_done beats a same-cycle expiry
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      h0_done_c = 1'b0;
      h1_done_c = 1'b0;
      timeout_c = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            // Host 0 wins alone, under fixed priority, or when host 1 went last
            if (req0 && (!req1 || FIXED_PRIORITY || last_q)) begin
               state_d = ARB_OWN0;
            end else if (req1) begin
               state_d = ARB_OWN1;
            end
         end
         ARB_OWN0: begin
            if (dev.done || wd_expired) begin
               h0_done_c = 1'b1;
               timeout_c = !dev.done;
               last_d    = 1'b0;
               state_d   = ARB_IDLE;
            end
         end
         ARB_OWN1: begin
            if (dev.done || wd_expired) begin
               h1_done_c = 1'b1;
               timeout_c = !dev.done;
               last_d    = 1'b1;
               state_d   = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Request mux on the registered grant, so reset drops dev strobes at once
   assign h0_bus = '{addr: h0.addr, wdata: h0.wdata, wmask: h0.wmask, wen: h0.wen, ren: h0.ren};
   assign h1_bus = '{addr: h1.addr, wdata: h1.wdata, wmask: h1.wmask, wen: h1.wen, ren: h1.ren};

   always_comb begin
      dev_bus = '0;
      unique case (grant_q)
         2'b01:   dev_bus = h0_bus;
         2'b10:   dev_bus = h1_bus;
         default: dev_bus = '0;
      endcase
   end

   assign dev.addr  = dev_bus.addr;
   assign dev.wdata = dev_bus.wdata;
   assign dev.wmask = dev_bus.wmask;
   assign dev.wen   = dev_bus.wen;
   assign dev.ren   = dev_bus.ren;

   // Owner sees target data, or the watchdog pattern on a timed-out completion
   assign owner_rdata = (wd_expired && !dev.done) ? TIMEOUT_RDATA : dev.rdata;

   assign h0.rdata = (state_q == ARB_OWN0) ? owner_rdata : '0;
   assign h1.rdata = (state_q == ARB_OWN1) ? owner_rdata : '0;
   assign h0.done  = h0_done_c;
   assign h1.done  = h1_done_c;

   assign grant   = grant_q;
   assign timeout = timeout_c;

endmodule
